instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Fetch stage upstream of the single-cycle `CPU` core. It owns the fetch PC, issues word reads to a synchronous instruction memory, and buffers the returned words with their PC tags in a small FIFO. It presents {pc, instr} pairs to the core over a valid/ready handshake. A redirect input from the core's branch/jump logic flushes all buffered and in-flight fetches.

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `imem_req`  out  1  read strobe to instruction memory.
- `imem_addr`  out  32  byte address of read; bits [1:0] always 0.
- `imem_rdata`  in  32  read data; valid exactly one cycle after `imem_req`.
- `out_valid`  out  1  head entry available to core.
- `out_ready`  in  1  core accepts head this cycle.
- `out_pc`  out  32  PC of head entry.
- `out_instr`  out  32  instruction word of head entry.
- `redirect`  in  1  flush and restart fetch.
- `redirect_pc`  in  32  restart address; bits [1:0] ignored (forced 0).
- `fetch_count`  out  32  present only with `FETCH_STATS_EN`.

## Operation
- State: `fetch_pc`, FIFO (rd/wr pointers with extra wrap bit), `inflight` (1 bit), `inflight_pc`.
- Issue rule: `imem_req` = !reset && !redirect && (occupancy + inflight) < DEPTH. On issue: `imem_addr`=`fetch_pc`, `fetch_pc` += 4 (wraps mod 2^32), `inflight`←1, `inflight_pc`←`fetch_pc`.
- Response: cycle after issue, if not squashed, push {`inflight_pc`, `imem_rdata`}. The issue rule guarantees no overflow; no push is ever dropped for lack of space.
- Pop: `out_valid && out_ready`. `out_valid` = FIFO non-empty. `out_pc`/`out_instr` read combinationally from the head.
- Push and pop in the same cycle are both performed; occupancy unchanged.
- Redirect (cycle r): FIFO emptied, in-flight response of cycle r+1 discarded, `fetch_pc`←{`redirect_pc`[31:2],2'b00}, no issue in cycle r. A pop handshake in cycle r is ignored (flush wins).
- Redirect while empty/idle: same behaviour, harmless.
- Back-to-back redirects: last one wins. Each squashes any response due next cycle.
- Reset values: `fetch_pc`=RESET_PC, FIFO empty, `inflight`=0, `imem_req`=0, `imem_addr`=RESET_PC, `out_valid`=0, `out_pc`=0, `out_instr`=0, `fetch_count`=0.
- Reset asserted mid-operation: identical to power-on reset; pending response ignored.

## Timing
- Issue at t → entry pushed at end of t+1 → `out_valid` high at t+2. Minimum fetch-to-core latency is 2 cycles.
- Sustained throughput is 1 instr/cycle with `out_ready` held high. In steady state ≤1 request is in flight.
- Redirect at r → first issue at r+1 from new PC → `out_valid` at r+3.
- `out_ready` low: issue stops once occupancy+inflight = DEPTH. It resumes the cycle after the first pop.
- `out_valid` never drops without a pop, redirect or reset.

## Configuration
- `FETCH_STATS_EN` defined: `fetch_count` port exists. It increments by 1 on every pop handshake (not on issue, not on flushed entries) and wraps at 2^32. Reset clears it to 0.
- Undefined: port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `fetch_pkg`: `XLEN`=32, `PC_STEP`=4, typedef `fetch_entry_t` {pc[31:0], instr[31:0]}.
- One sub-module: `fetch_fifo` (parameter DEPTH; push/pop/flush, full/empty, occupancy).
- Issue/squash control stays in the top.

## Test plan
- Reset, `out_ready`=1, memory returns addr^32'hA5A5_0000. Expected: issues at 0x0, 0x4, 0x8… in consecutive cycles; first `out_valid` 2 cycles after reset release with pc=0x0, instr=0xA5A5_0000.
- `out_ready`=0 for 10 cycles. Expected: exactly 4 requests (0x0–0xC), then `imem_req` low. On release, the next request 0x10 issues the cycle after the first pop.
- Redirect to 0x0000_0103 while FIFO holds 3 entries and one is in flight. Expected: next request 0x100; no stale pc (0x0–0x10) ever appears on `out_*`.
- Redirect in two consecutive cycles (0x200 then 0x300). Expected: first issue 0x300; no 0x200 entry delivered.
- `RESET_PC`=32'hFFFF_FFF8, free-running. Expected: pcs FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
- With `FETCH_STATS_EN`, 7 pops then a redirect flushing 2 entries. Expected: `fetch_count`=7. Reset mid-run returns it to 0 and `out_valid` to 0 next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch queue.
//   XLEN          : datapath / address width
//   PC_STEP       : byte increment between sequential fetches
//   fetch_entry_t : {pc, instr} pair carried through the fetch FIFO
//   align_pc()    : force a byte address onto a word boundary
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small FIFO of {pc, instr} entries between imem and the core.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   push/push_data : write an entry at the tail
//   pop          : release the head entry (ignored when empty)
//   flush        : drop every entry; wins over push and pop
//   head         : head entry, zero when empty
//   full/empty   : status flags
//   count        : current number of stored entries (0..DEPTH)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_fifo: DEPTH must be a power of two >= 2");
  end

  fetch_entry_t mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty differ only by it.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the head is masked to zero whenever empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch stage in front of the single-cycle core.
// Owns the fetch PC, issues word reads to a synchronous instruction memory
// (data returns one cycle after the request), buffers {pc, instr} pairs and
// presents the head to the core over valid/ready. A redirect flushes every
// buffered and in-flight fetch and restarts from redirect_pc.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   imem_req/imem_addr    : read strobe and word-aligned byte address
//   imem_rdata            : read data, valid the cycle after imem_req
//   out_valid/out_ready   : head handshake to the core
//   out_pc/out_instr      : head entry (zero when empty)
//   redirect/redirect_pc  : flush and restart fetch (low 2 bits ignored)
//   fetch_count           : pop counter, only when FETCH_STATS_EN is defined
// Build option: `define FETCH_STATS_EN to add the fetch_count port/counter.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [XLEN-1:0] fetch_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;

  logic [CW-1:0]   occupancy;
  logic [CW:0]     committed;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  // Slots already promised: stored entries plus the response still in the
  // memory pipe. Issuing only below DEPTH means a push never finds it full.
  assign committed = {1'b0, occupancy} + {{CW{1'b0}}, inflight};

  assign imem_req  = !reset && !redirect && !fifo_full && (committed < DEPTH_L);
  assign imem_addr = fetch_pc;

  // The response arriving in a redirect cycle belongs to the old stream.
  assign push      = inflight && !redirect && !reset;
  assign push_data = '{pc: inflight_pc, instr: imem_rdata};

  // Flush wins over a pop handshake in the same cycle.
  assign pop       = out_valid && out_ready && !redirect;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      fetch_pc    <= align_pc(redirect_pc);
      inflight    <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc    <= fetch_pc + PC_STEP;
        inflight_pc <= fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (redirect),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (occupancy)
  );

  assign out_valid = !fifo_empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

`ifdef FETCH_STATS_EN
  // Counts only instructions actually handed to the core.
  always_ff @(posedge clk) begin
    if (reset)    fetch_count <= '0;
    else if (pop) fetch_count <= fetch_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: scoreboard bench for instr_fetch_queue.
// A behavioural model tracks the expected fetch PC and queue of {pc, instr}
// entries; entries are queued on modelled issue/response and popped and
// compared when the DUT hands an instruction to the core. A second instance
// with RESET_PC = 0xFFFF_FFF8 checks PC wrap-around.
module tb_instr_fetch_queue;
  import fetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT
  logic        reset, out_ready, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, out_valid;
  logic [31:0] imem_addr, imem_rdata, out_pc, out_instr;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] w_fetch_count;
`endif

  // wrap DUT
  logic        w_reset, w_out_ready, w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_imem_req, w_out_valid;
  logic [31:0] w_imem_addr, w_imem_rdata, w_out_pc, w_out_instr;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .redirect(redirect),
    .redirect_pc(redirect_pc)
`ifdef FETCH_STATS_EN
    , .fetch_count(fetch_count)
`endif
  );

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(w_reset), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_rdata(w_imem_rdata), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_pc(w_out_pc), .out_instr(w_out_instr), .redirect(w_redirect),
    .redirect_pc(w_redirect_pc)
`ifdef FETCH_STATS_EN
    , .fetch_count(w_fetch_count)
`endif
  );

  // Synchronous memories: data = addr ^ KEY one cycle after a request,
  // garbage otherwise so an unrequested push is visible.
  always @(posedge clk) imem_rdata   <= imem_req   ? (imem_addr   ^ KEY) : 32'hDEAD_BEEF;
  always @(posedge clk) w_imem_rdata <= w_imem_req ? (w_imem_addr ^ KEY) : 32'hDEAD_BEEF;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // model state
  bit           m_ok = 1'b0;
  bit           m_infl;
  logic [31:0]  m_pc, m_ipc;
  fetch_entry_t m_q[$];
  int unsigned  m_cnt, m_pops;
  bit           w_ok = 1'b0;
  logic [31:0]  w_exp[$];

  // observations from the last completed cycle
  bit           o_req, o_valid;
  logic [31:0]  o_addr, o_pc;

  // One clock cycle: inputs are already applied; sample at negedge, compare,
  // advance the model, then move just past the rising edge.
  task automatic tick();
    bit e_req, e_valid, e_pop;
    @(negedge clk);
    o_req = imem_req; o_addr = imem_addr; o_valid = out_valid; o_pc = out_pc;
    if (m_ok) begin
      e_req   = !reset && !redirect && (m_q.size() + int'(m_infl)) < DEPTH;
      e_valid = m_q.size() != 0;
      chk("imem_req",  32'(imem_req),  32'(e_req));
      chk("imem_addr", imem_addr, m_pc);
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      chk("out_pc",    out_pc,    e_valid ? m_q[0].pc    : 32'h0);
      chk("out_instr", out_instr, e_valid ? m_q[0].instr : 32'h0);
`ifdef FETCH_STATS_EN
      chk("fetch_count", fetch_count, m_cnt);
`endif
      e_pop = e_valid && out_ready && !redirect;
      if (!reset && redirect) begin
        m_q.delete();
        m_infl = 1'b0;
        m_pc   = {redirect_pc[31:2], 2'b00};
      end else if (!reset) begin
        if (e_pop) begin
          void'(m_q.pop_front());
          m_cnt++;
          m_pops++;
        end
        if (m_infl) m_q.push_back(fetch_entry_t'{pc: m_ipc, instr: m_ipc ^ KEY});
        if (e_req) begin
          m_ipc = m_pc;
          m_pc  = m_pc + 32'd4;
        end
        m_infl = e_req;
      end
    end
    if (reset) begin
      m_ok = 1'b1; m_pc = 32'h0; m_q.delete(); m_infl = 1'b0; m_cnt = 0;
    end
    // wrap instance: ready always high, check delivered sequence
    if (w_ok && w_out_valid && w_exp.size() != 0) begin
      chk("wrap_pc",    w_out_pc,    w_exp[0]);
      chk("wrap_instr", w_out_instr, w_exp[0] ^ KEY);
      void'(w_exp.pop_front());
    end
    if (w_reset) w_ok = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, nreq;
    reset = 1'b1; out_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    w_reset = 1'b1; w_out_ready = 1'b1; w_redirect = 1'b0; w_redirect_pc = 32'h0;
    w_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};

    repeat (2) tick();
    chk("rst_req",   32'(o_req),   32'h0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_addr",  o_addr,       32'h0);

    // free run from reset
    reset = 1'b0; w_reset = 1'b0;
    tick();
    chk("first_req",  32'(o_req), 32'h1);
    chk("first_addr", o_addr,     32'h0);
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      lat++;
      if (o_valid) break;
    end
    chk("first_valid_lat", lat,  32'd2);
    chk("first_pc",        o_pc, 32'h0);
    repeat (8) tick();

    // mid-run reset, then stall with out_ready low
    reset = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b0;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) chk("midrst_valid", 32'(o_valid), 32'h0);
      if (o_req) nreq++;
    end
    chk("stall_reqs", nreq, 32'd4);

    // release: first pop cycle has no issue, next cycle issues 0x10
    out_ready = 1'b1;
    tick();
    chk("pop_cycle_req", 32'(o_req), 32'h0);
    tick();
    chk("resume_req",  32'(o_req), 32'h1);
    chk("resume_addr", o_addr,     32'h10);
    repeat (4) tick();

    // build 3 stored + 1 in flight, then redirect
    out_ready = 1'b0;
    for (int i = 0; i < 12 && !(m_q.size() == 3 && m_infl); i++) tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0103; out_ready = 1'b1;
    tick();
    chk("redir_cycle_req", 32'(o_req), 32'h0);
    redirect = 1'b0;
    tick();
    chk("redir_req",   32'(o_req), 32'h1);
    chk("redir_addr",  o_addr,     32'h100);
    chk("redir_valid", 32'(o_valid), 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_valid) chk("no_stale_pc", 32'(o_pc >= 32'h100), 32'h1);
    end

    // back-to-back redirects: last wins
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    tick();
    chk("b2b_req",  32'(o_req), 32'h1);
    chk("b2b_addr", o_addr,     32'h300);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_valid) chk("no_0x200_pc", 32'(o_pc[31:8] == 24'h2), 32'h0);
    end

    // pop counting: 7 pops, then flush 2 entries
    reset = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b1; m_pops = 0;
    for (int i = 0; i < 30 && m_pops < 7; i++) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 6 && m_q.size() < 2; i++) tick();
    redirect = 1'b1; redirect_pc = 32'h400; out_ready = 1'b1;
    tick();
    redirect = 1'b0;
    tick();
    chk("flush_valid", 32'(o_valid), 32'h0);
`ifdef FETCH_STATS_EN
    chk("stats_count_7", fetch_count, 32'd7);
`endif
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("rst2_valid", 32'(o_valid), 32'h0);
`ifdef FETCH_STATS_EN
    chk("stats_count_rst", fetch_count, 32'd0);
`endif

    chk("wrap_seq_done", w_exp.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
